// File: rtl/knn_topk_tracker.sv
// rtl/knn_topk_tracker.sv - keeps the K nearest (distance, id) candidates of a query and drains them in ascending order
module knn_topk_tracker #(
    parameter int DIST_W = 32,
    parameter int ID_W   = 16,
    parameter int K      = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic                   data_valid_in,
    output logic                   data_ready_out,
    input  logic [DIST_W-1:0]      distance_sq_in,
    input  logic [ID_W-1:0]        vertex_id_in,
    input  logic                   last_in,
    output logic                   result_valid_out,
    input  logic                   result_ready_in,
    output logic [DIST_W-1:0]      result_distance_out,
    output logic [ID_W-1:0]        result_id_out,
    output logic [$clog2(K):0]     result_rank_out,
    output logic [$clog2(K):0]     result_count_out,
    output logic                   done_out
);
    localparam int CW = $clog2(K) + 1;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [DIST_W-1:0] slot_dist [K];
    logic [ID_W-1:0]   slot_id   [K];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     ptr_q;
    logic              done_q, done_d;

    logic              accept, dup, ins_found, do_ins, hs;
    logic [CW-1:0]     ins_pos;
    logic [IW-1:0]     ptr_idx;

    // Slot i is valid when i < count; the lowest slot that is empty or strictly farther wins.
    always_comb begin
        dup       = 1'b0;
        ins_found = 1'b0;
        ins_pos   = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (CW'(i) < count_q && slot_id[i] == vertex_id_in)
                dup = 1'b1;
            if (CW'(i) >= count_q || slot_dist[i] > distance_sq_in) begin
                ins_found = 1'b1;
                ins_pos   = CW'(i);
            end
        end
    end

    assign accept  = (state_q == S_COLLECT) && data_valid_in;
    assign do_ins  = accept && !start_in && !dup && ins_found;
    assign ptr_idx = ptr_q[IW-1:0];

    always_comb begin
        data_ready_out   = (state_q == S_COLLECT);
        result_valid_out = (state_q == S_DRAIN) && (ptr_q < count_q);
        hs               = result_valid_out && result_ready_in;
    end

    always_comb begin
        result_distance_out = '0;
        result_id_out       = '0;
        result_rank_out     = '0;
        if (result_valid_out) begin
            result_distance_out = slot_dist[ptr_idx];
            result_id_out       = slot_id[ptr_idx];
            result_rank_out     = ptr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_in) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (start_in)                state_d = S_COLLECT;
                else if (accept && last_in)  state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (start_in) begin
                    state_d = S_COLLECT;
                end else if (count_q == '0 || (hs && ptr_q == count_q - CW'(1))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count_q <= '0;
            ptr_q   <= '0;
        end else begin
            if (start_in)
                count_q <= '0;
            else if (do_ins && count_q != CW'(K))
                count_q <= count_q + CW'(1);
            if (start_in || state_q != S_DRAIN)
                ptr_q <= '0;
            else if (hs)
                ptr_q <= ptr_q + CW'(1);
        end
    end

    // Insert at ins_pos, shift the tail down; slot K-1 falls off when full.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < K; i++) begin
                slot_dist[i] <= '0;
                slot_id[i]   <= '0;
            end
        end else if (do_ins) begin
            for (int i = 0; i < K; i++) begin
                if (CW'(i) == ins_pos) begin
                    slot_dist[i] <= distance_sq_in;
                    slot_id[i]   <= vertex_id_in;
                end
            end
            for (int i = 1; i < K; i++) begin
                if (CW'(i) > ins_pos) begin
                    slot_dist[i] <= slot_dist[i-1];
                    slot_id[i]   <= slot_id[i-1];
                end
            end
        end
    end

    assign result_count_out = count_q;
    assign done_out         = done_q;
endmodule

// File: tb/tb_knn_topk_tracker.sv
// tb/tb_knn_topk_tracker.sv - directed and random checks of knn_topk_tracker against a sorted-queue model
module tb_knn_topk_tracker;
    localparam int DIST_W = 32;
    localparam int ID_W   = 16;
    localparam int K      = 4;
    localparam int CW     = $clog2(K) + 1;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              start_in = 1'b0;
    logic              data_valid_in = 1'b0;
    logic              data_ready_out;
    logic [DIST_W-1:0] distance_sq_in = '0;
    logic [ID_W-1:0]   vertex_id_in = '0;
    logic              last_in = 1'b0;
    logic              result_valid_out;
    logic              result_ready_in = 1'b0;
    logic [DIST_W-1:0] result_distance_out;
    logic [ID_W-1:0]   result_id_out;
    logic [CW-1:0]     result_rank_out;
    logic [CW-1:0]     result_count_out;
    logic              done_out;

    int errors = 0;
    int checks = 0;

    logic [DIST_W-1:0] md [$];
    logic [ID_W-1:0]   mi [$];

    knn_topk_tracker #(.DIST_W(DIST_W), .ID_W(ID_W), .K(K)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .data_valid_in(data_valid_in), .data_ready_out(data_ready_out),
        .distance_sq_in(distance_sq_in), .vertex_id_in(vertex_id_in), .last_in(last_in),
        .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
        .result_distance_out(result_distance_out), .result_id_out(result_id_out),
        .result_rank_out(result_rank_out), .result_count_out(result_count_out),
        .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_insert(input logic [DIST_W-1:0] d, input logic [ID_W-1:0] id);
        int pos;
        foreach (mi[i]) if (mi[i] == id) return;
        pos = 0;
        while (pos < md.size() && md[pos] <= d) pos++;
        if (pos >= K) return;
        md.insert(pos, d);
        mi.insert(pos, id);
        if (md.size() > K) begin
            void'(md.pop_back());
            void'(mi.pop_back());
        end
    endfunction

    task automatic start_q();
        start_in = 1'b1;
        md.delete();
        mi.delete();
        @(negedge clk_in);
        start_in = 1'b0;
        chk("start_ready", data_ready_out, 1);
        chk("start_count", result_count_out, 0);
        chk("start_valid", result_valid_out, 0);
    endtask

    task automatic send(input logic [DIST_W-1:0] d, input logic [ID_W-1:0] id, input bit last);
        data_valid_in  = 1'b1;
        distance_sq_in = d;
        vertex_id_in   = id;
        last_in        = last;
        model_insert(d, id);
        @(negedge clk_in);
        data_valid_in = 1'b0;
        last_in       = 1'b0;
        chk("insert_count", result_count_out, md.size());
    endtask

    // mode 0: ready always, 1: ready pattern 1,0,0 repeating, 2: random
    task automatic drain_check(input int mode);
        int  idx = 0;
        int  cyc = 0;
        bit  rdy;
        chk("drain_first_valid", result_valid_out, md.size() > 0);
        if (md.size() == 0) begin
            chk("empty_done_early", done_out, 0);
            @(negedge clk_in);
            chk("empty_done", done_out, 1);
            chk("empty_valid", result_valid_out, 0);
            @(negedge clk_in);
            chk("empty_done_clear", done_out, 0);
            return;
        end
        while (idx < md.size() && cyc < 200) begin
            chk("drain_valid", result_valid_out, 1);
            chk("drain_dist", result_distance_out, md[idx]);
            chk("drain_id", result_id_out, mi[idx]);
            chk("drain_rank", result_rank_out, idx);
            chk("drain_no_done", done_out, 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3) == 0;
                default: rdy = $urandom_range(0, 1) == 1;
            endcase
            result_ready_in = rdy;
            @(negedge clk_in);
            if (rdy) idx++;
            cyc++;
        end
        chk("drain_timeout", cyc < 200, 1);
        result_ready_in = 1'b0;
        chk("done_pulse", done_out, 1);
        chk("done_valid_low", result_valid_out, 0);
        chk("done_count", result_count_out, md.size());
        @(negedge clk_in);
        chk("done_one_cycle", done_out, 0);
        chk("idle_ready_low", data_ready_out, 0);
    endtask

    task automatic query_a();
        send(50, 1, 0); send(10, 2, 0); send(30, 3, 0);
        send(10, 4, 0); send(70, 5, 0); send(5, 6, 1);
    endtask

    initial begin
        #3;
        chk("rst_ready", data_ready_out, 0);
        chk("rst_valid", result_valid_out, 0);
        chk("rst_dist", result_distance_out, 0);
        chk("rst_id", result_id_out, 0);
        chk("rst_rank", result_rank_out, 0);
        chk("rst_count", result_count_out, 0);
        chk("rst_done", done_out, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("idle_ready", data_ready_out, 0);

        // Candidates presented while idle are ignored
        data_valid_in = 1'b1; distance_sq_in = 1; vertex_id_in = 1; last_in = 1'b1;
        @(negedge clk_in);
        data_valid_in = 1'b0; last_in = 1'b0;
        chk("idle_ignore_count", result_count_out, 0);
        chk("idle_ignore_valid", result_valid_out, 0);

        start_q(); query_a(); drain_check(0);
        chk("qa_size", md.size(), 4);

        start_q(); send(20, 7, 0); send(3, 7, 0); send(40, 8, 1); drain_check(0);
        chk("dup_size", md.size(), 2);

        start_q(); query_a(); drain_check(1);

        start_q(); send(100, 9, 1); drain_check(0);
        start_q(); send(100, 9, 0); send(50, 9, 1); drain_check(2);

        // Restart in the middle of a drain
        start_q(); query_a();
        result_ready_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("mid_rank2", result_rank_out, 2);
        result_ready_in = 1'b0;
        start_q();
        chk("mid_no_done", done_out, 0);
        @(negedge clk_in);
        chk("mid_no_done2", done_out, 0);
        send(8, 3, 0); send(2, 4, 1); drain_check(0);

        // Asynchronous reset between clock edges
        start_q(); send(11, 1, 0); send(12, 2, 0);
        #2 rst_in = 1'b0;
        #1;
        chk("arst_ready", data_ready_out, 0);
        chk("arst_count", result_count_out, 0);
        chk("arst_valid", result_valid_out, 0);
        chk("arst_done", done_out, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("arst_idle_ready", data_ready_out, 0);
        end

        for (int q = 0; q < 25; q++) begin
            int n;
            start_q();
            n = $urandom_range(1, 12);
            for (int j = 0; j < n; j++) begin
                logic [DIST_W-1:0] d;
                logic [ID_W-1:0]   id;
                d  = ($urandom_range(0, 3) == 0) ? DIST_W'($urandom) : DIST_W'($urandom_range(0, 20));
                id = ID_W'($urandom_range(1, 10));
                send(d, id, j == n - 1);
            end
            drain_check(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/knn_topk_tracker.md
# knn_topk_tracker

Downstream consumer of the squared-distance stage: accepts a stream of (squared distance, vertex id) candidates for one query, keeps the K smallest in a sorted on-chip list, and drains them in ascending-distance order through a valid/ready port. It is the selection stage of the nearest-neighbour search datapath, sitting between the distance calculator and the search controller.

## Interface
- DIST_W, 32, width of squared distance (matches distance stage output)
- ID_W, 16, vertex id width
- K, 4, list depth (number of neighbours kept), 1..16
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- start_in  input  1  one-cycle pulse: clear list, begin a new query
- data_valid_in  input  1  candidate present
- data_ready_out  output  1  candidate can be accepted this cycle
- distance_sq_in  input  DIST_W  candidate squared distance
- vertex_id_in  input  ID_W  candidate vertex id
- last_in  input  1  qualifies final candidate of the query
- result_valid_out  output  1  result entry present
- result_ready_in  input  1  downstream accepts result entry
- result_distance_out  output  DIST_W  entry distance
- result_id_out  output  ID_W  entry vertex id
- result_rank_out  output  $clog2(K)+1  entry rank, 0 = nearest
- result_count_out  output  $clog2(K)+1  number of valid entries in list
- done_out  output  1  one-cycle pulse after final entry drained

## Operation
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE: data_ready_out=0; candidates ignored. start_in -> COLLECT, list cleared (count=0).
- COLLECT: data_ready_out=1. Accept = data_valid_in && data_ready_out.
- Insertion: compare new distance against all K slots in parallel; insert at first slot whose distance is strictly greater or that is empty; slots below shift down one; entry shifted out of slot K-1 is discarded.
- Ties: equal distance inserts after existing entry (stable, earlier arrival ranks first).
- Full list and new distance >= slot K-1 distance: candidate dropped, list unchanged.
- Duplicate id: if vertex_id_in matches any valid slot id, candidate dropped regardless of distance.
- count increments on successful insert while count<K; saturates at K.
- Accepted candidate with last_in=1 (inserted or dropped) -> DRAIN.
- DRAIN: data_ready_out=0; rank pointer from 0; result_valid_out=1 while pointer<count; outputs show slot[pointer]. Handshake (valid && ready) advances pointer. After handshake of rank count-1 -> IDLE with done_out pulse.
- count==0 on entering DRAIN: no result_valid_out; done_out pulses on the next cycle, -> IDLE.
- start_in has priority in every state: clears list, pointer, goes COLLECT; any in-progress drain abandoned, no done_out.
- Distances unsigned; no arithmetic beyond compares.

## Timing
- Reset (rst_in=0, async): state IDLE, count=0, all slots invalid, data_ready_out=0, result_valid_out=0, result_distance_out=0, result_id_out=0, result_rank_out=0, result_count_out=0, done_out=0.
- start_in at cycle t -> data_ready_out=1 at t+1.
- Accepted candidate at cycle t visible in list (result_count_out) at t+1; one candidate per cycle sustained, no bubbles.
- last_in accepted at t -> result_valid_out=1 with rank 0 at t+1.
- Drain: one entry per cycle when result_ready_in held high; result outputs stable while valid && !ready.
- done_out asserted the cycle after final handshake, for exactly one cycle; state IDLE that same cycle.
- result_count_out is registered, reflects list occupancy in all states.

## Test plan
- K=4, ids 1..6 with distances 50,10,30,10,70,5, last on 6th -> drain (6,5),(2,10),(4,10),(3,30), ranks 0..3, done_out one cycle after 4th handshake.
- Duplicate: (7,20),(7,3),(8,40) last -> drain (7,20),(8,40); count=2.
- Backpressure: result_ready_in toggled 1,0,0,1... -> outputs hold during stalls, no entry skipped or repeated.
- Empty query: start then single candidate id 9 dist 100 with last... and variant with last on dropped duplicate; separately start then last-only on empty list never taken -> with count=0, result_valid_out stays 0, done_out pulses t+2 after last accept.
- start_in mid-drain after rank 1 handshake -> result_valid_out drops next cycle, no done_out, count=0, new query collects normally.
- Async reset asserted mid-COLLECT between clock edges -> all outputs at reset values immediately, data_ready_out=0 after release until start_in.
